// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the four-slot TDM demultiplexer.
package tdm_demux4_pkg;

    localparam int unsigned NSLOT = 4;

    typedef enum logic {
        HUNT,
        RECV
    } tdm_state_t;

    typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// Serial-in / parallel-out bundle of the TDM demultiplexer.
interface tdm_demux4_if
    import tdm_demux4_pkg::*;
#(
    parameter int unsigned DW = 1
);

    logic [DW-1:0]       in;
    logic                in_vld;
    logic                frame;
    logic [NSLOT*DW-1:0] out;
    logic                out_vld;
    slot_t               sel;
    logic                err;

    modport master (
        output in, in_vld, frame,
        input  out, out_vld, sel, err
    );

    modport slave (
        input  in, in_vld, frame,
        output out, out_vld, sel, err
    );

endinterface

// File: rtl/demux_dec2to4.sv
// One-hot write-enable decoder: the structural inverse of a 4-to-1 mux select.
module demux_dec2to4
    import tdm_demux4_pkg::*;
(
    input  slot_t              sel,
    input  logic               en,
    output logic [NSLOT-1:0]   we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: steers interleaved serial samples into lanes
// and publishes each complete frame as one registered word with a valid pulse.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int unsigned DW = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);

    tdm_state_t                 state;
    slot_t                      sel_q;
    logic [NSLOT-2:0][DW-1:0]   shadow;
    logic [NSLOT*DW-1:0]        out_q;
    logic                       out_vld_q;
    logic                       err_q;

    slot_t                      wr_slot;
    logic                       wr_en;
    logic [NSLOT-1:0]           we;

    // A frame marker always restarts at slot 0, regardless of the counter.
    assign wr_slot = bus.frame ? slot_t'(0) : sel_q;
    assign wr_en   = bus.in_vld & (bus.frame | (state == RECV));

    demux_dec2to4 u_dec (
        .sel (wr_slot),
        .en  (wr_en),
        .we  (we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            sel_q     <= '0;
            shadow    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;

            for (int unsigned k = 0; k < NSLOT - 1; k++) begin
                if (we[k]) begin
                    shadow[k] <= bus.in;
                end
            end

            // we[3] only fires in RECV on a non-marker slot-3 beat.
            if (we[NSLOT-1]) begin
                out_q     <= {bus.in, shadow};
                out_vld_q <= 1'b1;
            end

            if (bus.in_vld) begin
                if (bus.frame) begin
                    err_q <= (state == RECV);
                    sel_q <= 2'd1;
                    state <= RECV;
                end else if (state == RECV) begin
                    if (sel_q == 2'd3) begin
                        sel_q <= 2'd0;
                        state <= HUNT;
                    end else begin
                        sel_q <= sel_q + 2'd1;
                    end
                end
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.out_vld = out_vld_q;
    assign bus.sel     = sel_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (DW=1) with hand-computed expectations.
module tb_tdm_demux4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pulses;

    tdm_demux4_if #(.DW(1)) bus ();

    tdm_demux4 #(.DW(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the falling edge, then settle just after the rising edge.
    task automatic cyc(input logic vld, input logic frm, input logic din);
        @(negedge clk);
        bus.in_vld = vld;
        bus.frame  = frm;
        bus.in     = din;
        @(posedge clk);
        #1;
        if (bus.out_vld === 1'b1) pulses++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pulses = 0;
        rst_n      = 1'b0;
        bus.in     = 1'b0;
        bus.in_vld = 1'b0;
        bus.frame  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        chk("rst_out",     32'(bus.out),     32'h0);
        chk("rst_out_vld", 32'(bus.out_vld), 32'h0);
        chk("rst_err",     32'(bus.err),     32'h0);
        chk("rst_sel",     32'(bus.sel),     32'h0);

        // Reset mid-frame after two beats
        cyc(1, 1, 1);
        cyc(1, 0, 0);
        chk("pre_rst_sel", 32'(bus.sel), 32'h2);
        @(negedge clk);
        bus.in_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(bus.sel), 32'h0);
        chk("mid_rst_out", 32'(bus.out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame 1,0,1,1 -> 1101, sel 1,2,3,0
        cyc(1, 1, 1);
        chk("basic_sel1", 32'(bus.sel), 32'h1);
        chk("basic_vld1", 32'(bus.out_vld), 32'h0);
        cyc(1, 0, 0);
        chk("basic_sel2", 32'(bus.sel), 32'h2);
        cyc(1, 0, 1);
        chk("basic_sel3", 32'(bus.sel), 32'h3);
        chk("basic_vld3", 32'(bus.out_vld), 32'h0);
        cyc(1, 0, 1);
        chk("basic_sel0", 32'(bus.sel), 32'h0);
        chk("basic_vld",  32'(bus.out_vld), 32'h1);
        chk("basic_out",  32'(bus.out), 32'hD);
        chk("basic_err",  32'(bus.err), 32'h0);
        cyc(0, 0, 0);
        chk("basic_vld_drop", 32'(bus.out_vld), 32'h0);
        chk("basic_out_hold", 32'(bus.out), 32'hD);

        // Back-to-back 0,0,1,0 then 1,1,1,1
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        chk("b2b_vld_a", 32'(bus.out_vld), 32'h1);
        chk("b2b_out_a", 32'(bus.out), 32'h4);
        cyc(1, 1, 1);
        chk("b2b_nobubble_sel", 32'(bus.sel), 32'h1);
        chk("b2b_err", 32'(bus.err), 32'h0);
        chk("b2b_vld_gap", 32'(bus.out_vld), 32'h0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        chk("b2b_vld_gap3", 32'(bus.out_vld), 32'h0);
        chk("b2b_out_hold", 32'(bus.out), 32'h4);
        cyc(1, 0, 1);
        chk("b2b_vld_b", 32'(bus.out_vld), 32'h1);
        chk("b2b_out_b", 32'(bus.out), 32'hF);

        // Stalled frame 1,0,1,1 with 1..3 idle cycles between beats
        pulses = 0;
        cyc(1, 1, 1);
        cyc(0, 1, 0);
        chk("stall_sel_hold1", 32'(bus.sel), 32'h1);
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        chk("stall_sel_hold2", 32'(bus.sel), 32'h2);
        chk("stall_out_hold", 32'(bus.out), 32'hF);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        chk("stall_sel_hold3", 32'(bus.sel), 32'h3);
        cyc(1, 0, 1);
        chk("stall_vld", 32'(bus.out_vld), 32'h1);
        chk("stall_out", 32'(bus.out), 32'hD);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("stall_pulses", 32'(pulses), 32'h1);

        // Resync: marker, beat, early marker, then 0,1,0 -> err, then 0100
        pulses = 0;
        cyc(1, 1, 1);
        cyc(1, 0, 1);
        cyc(1, 1, 0);
        chk("resync_err", 32'(bus.err), 32'h1);
        chk("resync_vld", 32'(bus.out_vld), 32'h0);
        chk("resync_sel", 32'(bus.sel), 32'h1);
        chk("resync_out_hold", 32'(bus.out), 32'hD);
        cyc(1, 0, 0);
        chk("resync_err_drop", 32'(bus.err), 32'h0);
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        chk("resync_vld_new", 32'(bus.out_vld), 32'h1);
        chk("resync_out_new", 32'(bus.out), 32'h4);
        chk("resync_pulses", 32'(pulses), 32'h1);

        // Hunt discard after reset, then frame 0,1,1,0 -> 0110
        @(negedge clk);
        bus.in_vld = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        cyc(1, 0, 1);
        chk("hunt_err1", 32'(bus.err), 32'h0);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("hunt_err3", 32'(bus.err), 32'h0);
        chk("hunt_sel", 32'(bus.sel), 32'h0);
        chk("hunt_pulses", 32'(pulses), 32'h0);
        cyc(1, 1, 0);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 0);
        chk("hunt_vld", 32'(bus.out_vld), 32'h1);
        chk("hunt_out", 32'(bus.out), 32'h6);
        chk("hunt_err_end", 32'(bus.err), 32'h0);

        cyc(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
